// File: rtl/xbus_pkg.sv
// rtl/xbus_pkg.sv - shared types and constants for the Xosera bus sequencer
package xbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } xbus_state_t;

    localparam logic XBUS_EVEN = 1'b0;
    localparam logic XBUS_ODD  = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [3:0]  reg_num;
        logic [15:0] data;
    } xbus_req_t;

endpackage

// File: rtl/xbus_if.sv
// rtl/xbus_if.sv - requester handshakes and Xosera bus pins of the sequencer
interface xbus_if;
    logic        req0_valid_i;
    logic        req0_ready_o;
    logic        req0_wr_i;
    logic [3:0]  req0_reg_i;
    logic [15:0] req0_data_i;
    logic        rsp0_valid_o;
    logic [15:0] rsp0_data_o;

    logic        req1_valid_i;
    logic        req1_ready_o;
    logic        req1_wr_i;
    logic [3:0]  req1_reg_i;
    logic [15:0] req1_data_i;
    logic        rsp1_valid_o;
    logic [15:0] rsp1_data_o;

    logic        xbus_cs_n_o;
    logic        xbus_rd_nwr_o;
    logic [3:0]  xbus_reg_num_o;
    logic        xbus_bytesel_o;
    logic [7:0]  xbus_data_o;
    logic [7:0]  xbus_data_i;
    logic        busy_o;

    modport slave (
        input  req0_valid_i, req0_wr_i, req0_reg_i, req0_data_i,
        input  req1_valid_i, req1_wr_i, req1_reg_i, req1_data_i,
        input  xbus_data_i,
        output req0_ready_o, rsp0_valid_o, rsp0_data_o,
        output req1_ready_o, rsp1_valid_o, rsp1_data_o,
        output xbus_cs_n_o, xbus_rd_nwr_o, xbus_reg_num_o, xbus_bytesel_o, xbus_data_o,
        output busy_o
    );

    modport master (
        output req0_valid_i, req0_wr_i, req0_reg_i, req0_data_i,
        output req1_valid_i, req1_wr_i, req1_reg_i, req1_data_i,
        output xbus_data_i,
        input  req0_ready_o, rsp0_valid_o, rsp0_data_o,
        input  req1_ready_o, rsp1_valid_o, rsp1_data_o,
        input  xbus_cs_n_o, xbus_rd_nwr_o, xbus_reg_num_o, xbus_bytesel_o, xbus_data_o,
        input  busy_o
    );
endinterface

// File: rtl/xbus_arbiter2.sv
// rtl/xbus_arbiter2.sv - two-way grant logic, round-robin when XBUS_ROUND_ROBIN_EN is defined
module xbus_arbiter2 (
`ifdef XBUS_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       reset_ni,
    input  logic       accept_i,
`endif
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

`ifdef XBUS_ROUND_ROBIN_EN
    // last_q holds the port granted most recently; starts at 1 so port 0 wins first
    logic last_q;
    logic last_d;

    // grant the port that was not served last when both request
    always_comb begin
        grant_o = valid_i;
        if (valid_i[0] && valid_i[1]) begin
            grant_o = last_q ? 2'b01 : 2'b10;
        end
    end

    // pointer follows each accepted grant
    always_comb begin
        last_d = last_q;
        if (accept_i) begin
            last_d = grant_o[1];
        end
    end

    // pointer register
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // fixed priority: port 0 always wins
    always_comb begin
        grant_o    = 2'b00;
        grant_o[0] = valid_i[0];
        grant_o[1] = valid_i[1] & ~valid_i[0];
    end
`endif

endmodule

// File: rtl/xbus_sequencer.sv
// rtl/xbus_sequencer.sv - arbitrates two requesters and runs even/odd Xosera byte cycles (XBUS_ROUND_ROBIN_EN selects round-robin)
module xbus_sequencer #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic    clk,
    input  logic    reset_ni,
    xbus_if.slave   bus
);
    import xbus_pkg::*;

    if (SETUP_CYCLES < 0 || SETUP_CYCLES > 7) begin : g_bad_setup
        $error("xbus_sequencer: SETUP_CYCLES must be 0..7");
    end
    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 7) begin : g_bad_strobe
        $error("xbus_sequencer: STROBE_CYCLES must be 1..7");
    end
    if (HOLD_CYCLES < 0 || HOLD_CYCLES > 7) begin : g_bad_hold
        $error("xbus_sequencer: HOLD_CYCLES must be 0..7");
    end

    // terminal counts; unused when the matching state is skipped
    localparam logic [2:0] SETUP_LAST  = 3'(SETUP_CYCLES - 1);
    localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYCLES - 1);
    localparam logic [2:0] HOLD_LAST   = 3'(HOLD_CYCLES - 1);

    xbus_state_t state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic        port_q, port_d;
    xbus_req_t   req_q, req_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] rsp0_data_q, rsp0_data_d;
    logic [15:0] rsp1_data_q, rsp1_data_d;

    logic [1:0]  grant;
    logic        idle;
    logic        accept;
    xbus_state_t byte_first;

    assign idle   = (state_q == ST_IDLE);
    assign accept = idle & (|grant);

    xbus_arbiter2 u_arb (
`ifdef XBUS_ROUND_ROBIN_EN
        .clk      (clk),
        .reset_ni (reset_ni),
        .accept_i (accept),
`endif
        .valid_i  ({bus.req1_valid_i, bus.req0_valid_i}),
        .grant_o  (grant)
    );

    // ready only while idle, never to both ports
    assign bus.req0_ready_o = idle & grant[0];
    assign bus.req1_ready_o = idle & grant[1];

    // each byte starts in SETUP unless it has zero length
    always_comb begin
        byte_first = ST_STROBE;
        if (SETUP_CYCLES > 0) begin
            byte_first = ST_SETUP;
        end
    end

    // sequencer next state, counters, request latch and read capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        port_d      = port_q;
        req_d       = req_q;
        rdata_d     = rdata_q;
        rsp0_data_d = rsp0_data_q;
        rsp1_data_d = rsp1_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    port_d  = grant[1];
                    req_d   = grant[1] ? '{wr: bus.req1_wr_i, reg_num: bus.req1_reg_i, data: bus.req1_data_i}
                                       : '{wr: bus.req0_wr_i, reg_num: bus.req0_reg_i, data: bus.req0_data_i};
                    phase_d = XBUS_EVEN;
                    cnt_d   = 3'd0;
                    state_d = byte_first;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d = 3'd0;
                    if (!req_q.wr) begin
                        if (phase_q == XBUS_EVEN) begin
                            rdata_d[15:8] = bus.xbus_data_i;
                        end else begin
                            rdata_d[7:0] = bus.xbus_data_i;
                        end
                    end
                    if (HOLD_CYCLES > 0) begin
                        state_d = ST_HOLD;
                    end else if (phase_q == XBUS_EVEN) begin
                        phase_d = XBUS_ODD;
                        state_d = byte_first;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = 3'd0;
                    if (phase_q == XBUS_EVEN) begin
                        phase_d = XBUS_ODD;
                        state_d = byte_first;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                cnt_d   = 3'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // read data becomes visible together with the completion pulse
        if (state_q != ST_DONE && state_d == ST_DONE && !req_q.wr) begin
            if (port_q) begin
                rsp1_data_d = rdata_d;
            end else begin
                rsp0_data_d = rdata_d;
            end
        end
    end

    // state and capture registers
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            phase_q     <= XBUS_EVEN;
            port_q      <= 1'b0;
            req_q       <= '0;
            rdata_q     <= 16'h0000;
            rsp0_data_q <= 16'h0000;
            rsp1_data_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            port_q      <= port_d;
            req_q       <= req_d;
            rdata_q     <= rdata_d;
            rsp0_data_q <= rsp0_data_d;
            rsp1_data_q <= rsp1_data_d;
        end
    end

    // bus pins decode from state so reset forces cs_n high immediately
    always_comb begin
        logic active;
        active             = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
        bus.xbus_cs_n_o    = (state_q != ST_STROBE);
        bus.xbus_rd_nwr_o  = active ? ~req_q.wr : 1'b1;
        bus.xbus_reg_num_o = active ? req_q.reg_num : 4'h0;
        bus.xbus_bytesel_o = active ? phase_q : 1'b0;
        bus.xbus_data_o    = 8'h00;
        if (active && req_q.wr) begin
            bus.xbus_data_o = (phase_q == XBUS_ODD) ? req_q.data[7:0] : req_q.data[15:8];
        end
    end

    assign bus.busy_o       = !idle;
    assign bus.rsp0_valid_o = (state_q == ST_DONE) && !port_q;
    assign bus.rsp1_valid_o = (state_q == ST_DONE) && port_q;
    assign bus.rsp0_data_o  = rsp0_data_q;
    assign bus.rsp1_data_o  = rsp1_data_q;

endmodule

// File: tb/tb_xbus_sequencer.sv
// tb/tb_xbus_sequencer.sv - scoreboard bench for xbus_sequencer (default and zero-setup/hold builds)
module tb_xbus_sequencer;

    logic clk;
    logic reset_ni;
    int   total;
    int   bad;
    int   cyc;
    logic [7:0] rd_hi;
    logic [7:0] rd_lo;

    typedef struct {
        logic        port;
        logic        rd;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    xbus_if bus0 ();
    xbus_if bus1 ();

    xbus_sequencer u0 (
        .clk      (clk),
        .reset_ni (reset_ni),
        .bus      (bus0)
    );

    xbus_sequencer #(
        .SETUP_CYCLES  (0),
        .STROBE_CYCLES (1),
        .HOLD_CYCLES   (0)
    ) u1 (
        .clk      (clk),
        .reset_ni (reset_ni),
        .bus      (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus0.xbus_data_i = bus0.xbus_cs_n_o ? 8'h00 : (bus0.xbus_bytesel_o ? rd_lo : rd_hi);
    assign bus1.xbus_data_i = 8'h5C;

    // response monitor for the default-timing instance
    always @(negedge clk) begin
        if (bus0.rsp0_valid_o || bus0.rsp1_valid_o) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_rsp got rsp0=%b rsp1=%b exp none", bus0.rsp0_valid_o, bus0.rsp1_valid_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus0.rsp1_valid_o !== e.port || bus0.rsp0_valid_o !== !e.port) begin
                    bad++;
                    $display("FAIL sb_rsp_port got rsp0=%b rsp1=%b exp port=%0d", bus0.rsp0_valid_o, bus0.rsp1_valid_o, e.port);
                end else if (e.rd) begin
                    logic [15:0] got;
                    got = e.port ? bus0.rsp1_data_o : bus0.rsp0_data_o;
                    if (got !== e.data) begin
                        bad++;
                        $display("FAIL sb_rsp_data got=%h exp=%h port=%0d", got, e.data, e.port);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        bus0.req0_valid_i = 0; bus0.req0_wr_i = 0; bus0.req0_reg_i = 0; bus0.req0_data_i = 0;
        bus0.req1_valid_i = 0; bus0.req1_wr_i = 0; bus0.req1_reg_i = 0; bus0.req1_data_i = 0;
        bus1.req0_valid_i = 0; bus1.req0_wr_i = 0; bus1.req0_reg_i = 0; bus1.req0_data_i = 0;
        bus1.req1_valid_i = 0; bus1.req1_wr_i = 0; bus1.req1_reg_i = 0; bus1.req1_data_i = 0;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus0.req0_ready_o, bus0.req1_ready_o, bus0.rsp0_valid_o, bus0.rsp1_valid_o, bus0.busy_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=00000", {bus0.req0_ready_o, bus0.req1_ready_o, bus0.rsp0_valid_o, bus0.rsp1_valid_o, bus0.busy_o});
        end
        total++;
        if ({bus0.rsp0_data_o, bus0.rsp1_data_o} !== 32'h0) begin
            bad++;
            $display("FAIL reset_rsp_data got=%h exp=0", {bus0.rsp0_data_o, bus0.rsp1_data_o});
        end
        total++;
        if ({bus0.xbus_cs_n_o, bus0.xbus_rd_nwr_o, bus0.xbus_reg_num_o, bus0.xbus_bytesel_o, bus0.xbus_data_o} !== 15'b11_0000_0_00000000) begin
            bad++;
            $display("FAIL reset_bus got=%b exp=110000000000000", {bus0.xbus_cs_n_o, bus0.xbus_rd_nwr_o, bus0.xbus_reg_num_o, bus0.xbus_bytesel_o, bus0.xbus_data_o});
        end
        reset_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_p0();
        logic exp_cs;
        logic [13:0] got_bus, exp_bus;
        @(negedge clk);
        bus0.req0_wr_i = 1; bus0.req0_reg_i = 4'd3; bus0.req0_data_i = 16'hA55A; bus0.req0_valid_i = 1;
        sb.push_back('{1'b0, 1'b0, 16'h0000});
        #1;
        total++;
        if (bus0.req0_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL wr_ready got=%b exp=1", bus0.req0_ready_o);
        end
        @(posedge clk); #1;
        bus0.req0_valid_i = 0; bus0.req0_data_i = 16'hFFFF; bus0.req0_reg_i = 4'hF; bus0.req0_wr_i = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_cs = !(k == 2 || k == 3 || k == 6 || k == 7);
            total++;
            if (bus0.xbus_cs_n_o !== exp_cs) begin
                bad++;
                $display("FAIL wr_cs_n cycle=%0d got=%b exp=%b", k, bus0.xbus_cs_n_o, exp_cs);
            end
            if (!exp_cs) begin
                got_bus = {bus0.xbus_bytesel_o, bus0.xbus_data_o, bus0.xbus_reg_num_o, bus0.xbus_rd_nwr_o};
                exp_bus = {(k >= 6), (k >= 6) ? 8'h5A : 8'hA5, 4'd3, 1'b0};
                total++;
                if (got_bus !== exp_bus) begin
                    bad++;
                    $display("FAIL wr_bus cycle=%0d got=%h exp=%h", k, got_bus, exp_bus);
                end
            end
            total++;
            if (bus0.rsp0_valid_o !== (k == 9)) begin
                bad++;
                $display("FAIL wr_rsp_valid cycle=%0d got=%b exp=%b", k, bus0.rsp0_valid_o, (k == 9));
            end
            total++;
            if (bus0.busy_o !== (k <= 9)) begin
                bad++;
                $display("FAIL wr_busy cycle=%0d got=%b exp=%b", k, bus0.busy_o, (k <= 9));
            end
        end
        total++;
        if (bus0.rsp0_data_o !== 16'h0000) begin
            bad++;
            $display("FAIL wr_rsp_data_unchanged got=%h exp=0000", bus0.rsp0_data_o);
        end
    endtask

    task automatic test_read_p1();
        int pulses;
        pulses = 0;
        rd_hi = 8'h12; rd_lo = 8'h34;
        @(negedge clk);
        bus0.req1_wr_i = 0; bus0.req1_reg_i = 4'd7; bus0.req1_data_i = 16'h0000; bus0.req1_valid_i = 1;
        sb.push_back('{1'b1, 1'b1, 16'h1234});
        @(posedge clk); #1;
        bus0.req1_valid_i = 0; bus0.req1_reg_i = 4'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus0.rsp1_valid_o) pulses++;
            if (k == 2) begin
                total++;
                if ({bus0.xbus_cs_n_o, bus0.xbus_rd_nwr_o, bus0.xbus_reg_num_o} !== {1'b0, 1'b1, 4'd7}) begin
                    bad++;
                    $display("FAIL rd_bus got=%b exp=%b", {bus0.xbus_cs_n_o, bus0.xbus_rd_nwr_o, bus0.xbus_reg_num_o}, {1'b0, 1'b1, 4'd7});
                end
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL rd_pulse_count got=%0d exp=1", pulses);
        end
        total++;
        if (bus0.rsp1_data_o !== 16'h1234) begin
            bad++;
            $display("FAIL rd_data_held got=%h exp=1234", bus0.rsp1_data_o);
        end
    endtask

    task automatic test_back_to_back();
        int grants[4];
        int when[4];
        int n;
        int budget;
        int exp_g[4];
`ifdef XBUS_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        rd_hi = 8'hC3; rd_lo = 8'h3C;
        @(negedge clk);
        reset_ni = 0;
        @(negedge clk);
        reset_ni = 1;
        bus0.req0_wr_i = 0; bus0.req0_reg_i = 4'd1; bus0.req0_valid_i = 1;
        bus0.req1_wr_i = 0; bus0.req1_reg_i = 4'd2; bus0.req1_valid_i = 1;
        n = 0;
        budget = 0;
        while (n < 4 && budget < 60) begin
            #1;
            if (bus0.req0_ready_o && bus0.req1_ready_o) begin
                total++; bad++;
                $display("FAIL arb_both_ready got=11 exp=one-hot");
            end
            if ((bus0.req0_ready_o || bus0.req1_ready_o) && bus0.busy_o) begin
                total++; bad++;
                $display("FAIL arb_ready_when_busy got=1 exp=0");
            end
            if (bus0.req0_ready_o || bus0.req1_ready_o) begin
                grants[n] = bus0.req1_ready_o ? 1 : 0;
                when[n] = cyc;
                sb.push_back('{bus0.req1_ready_o, 1'b1, 16'hC33C});
                n++;
            end
            @(posedge clk);
            if (n == 4) begin
                #1;
                bus0.req0_valid_i = 0; bus0.req1_valid_i = 0;
            end
            @(negedge clk);
            budget++;
        end
        bus0.req0_valid_i = 0; bus0.req1_valid_i = 0;
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL arb_timeout got=%0d grants exp=4", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (grants[i] != exp_g[i]) begin
                bad++;
                $display("FAIL arb_grant idx=%0d got=%0d exp=%0d", i, grants[i], exp_g[i]);
            end
            if (i > 0) begin
                total++;
                if (when[i] - when[i-1] != 10) begin
                    bad++;
                    $display("FAIL arb_interval idx=%0d got=%0d exp=10", i, when[i] - when[i-1]);
                end
            end
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus0.req0_wr_i = 0; bus0.req0_reg_i = 4'd9; bus0.req0_valid_i = 1;
        @(posedge clk); #1;
        bus0.req0_valid_i = 0;
        repeat (3) @(negedge clk);
        total++;
        if (bus0.xbus_cs_n_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_cs_before got=%b exp=0", bus0.xbus_cs_n_o);
        end
        reset_ni = 0;
        #1;
        total++;
        if ({bus0.xbus_cs_n_o, bus0.busy_o} !== 2'b10) begin
            bad++;
            $display("FAIL mid_cs_async got=%b exp=10", {bus0.xbus_cs_n_o, bus0.busy_o});
        end
        repeat (2) @(negedge clk);
        reset_ni = 1;
        repeat (10) @(negedge clk);
        total++;
        if (bus0.rsp0_data_o !== 16'h0000) begin
            bad++;
            $display("FAIL mid_rsp_data_cleared got=%h exp=0000", bus0.rsp0_data_o);
        end
        bus0.req0_wr_i = 1; bus0.req0_reg_i = 4'd2; bus0.req0_data_i = 16'h0102; bus0.req0_valid_i = 1;
        sb.push_back('{1'b0, 1'b0, 16'h0000});
        #1;
        total++;
        if (bus0.req0_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_after_ready got=%b exp=1", bus0.req0_ready_o);
        end
        @(posedge clk); #1;
        bus0.req0_valid_i = 0;
        repeat (9) @(negedge clk);
        total++;
        if (bus0.rsp0_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_after_rsp got=%b exp=1", bus0.rsp0_valid_o);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fast_timing();
        logic exp_cs;
        @(negedge clk);
        bus1.req0_wr_i = 0; bus1.req0_reg_i = 4'd5; bus1.req0_valid_i = 1;
        @(posedge clk); #1;
        bus1.req0_valid_i = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_cs = !(k == 1 || k == 2);
            total++;
            if (bus1.xbus_cs_n_o !== exp_cs) begin
                bad++;
                $display("FAIL fast_cs_n cycle=%0d got=%b exp=%b", k, bus1.xbus_cs_n_o, exp_cs);
            end
            if (!exp_cs) begin
                total++;
                if (bus1.xbus_bytesel_o !== (k == 2)) begin
                    bad++;
                    $display("FAIL fast_bytesel cycle=%0d got=%b exp=%b", k, bus1.xbus_bytesel_o, (k == 2));
                end
            end
            total++;
            if (bus1.rsp0_valid_o !== (k == 3)) begin
                bad++;
                $display("FAIL fast_rsp_valid cycle=%0d got=%b exp=%b", k, bus1.rsp0_valid_o, (k == 3));
            end
            if (k == 3) begin
                total++;
                if (bus1.rsp0_data_o !== 16'h5C5C) begin
                    bad++;
                    $display("FAIL fast_rsp_data got=%h exp=5C5C", bus1.rsp0_data_o);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        rd_hi = 8'h00;
        rd_lo = 8'h00;
        reset_ni = 1'b0;
        idle_inputs();
        test_reset();
        test_write_p0();
        test_read_p1();
        test_back_to_back();
        test_reset_mid();
        test_fast_timing();
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xbus_sequencer.md
# xbus_sequencer

Two-port arbiter and bus-cycle sequencer for the Xosera 8-bit register bus. It accepts 16-bit register read/write requests from two requesters, the CPU bridge (port 0) and the blitter/DMA engine (port 1). It arbitrates between them and expands each request into an even-byte then odd-byte Xosera bus cycle, with parameterised setup, strobe and hold timing. It sits between the SoC interconnect and the `xga` video subsystem's Xosera bus pins.

## Interface
Parameters:
- `SETUP_CYCLES`, default 1: cycles address, data and control are driven with `cs_n` high before the strobe; legal range 0..7.
- `STROBE_CYCLES`, default 2: cycles `cs_n` is held low per byte; legal range 1..7.
- `HOLD_CYCLES`, default 1: cycles `cs_n` is high after the strobe with address and data still held; legal range 0..7.

Ports:
- `clk`  in  1  system clock, the single clock domain.
- `reset_ni`  in  1  reset, asynchronous and active-low.
- `req0_valid_i` / `req1_valid_i`  in  1  request pending.
- `req0_ready_o` / `req1_ready_o`  out  1  grant; a request is accepted when valid and ready are both high at a clock edge.
- `req0_wr_i` / `req1_wr_i`  in  1  1 = write, 0 = read.
- `req0_reg_i` / `req1_reg_i`  in  4  Xosera register number.
- `req0_data_i` / `req1_data_i`  in  16  write data; even byte is [15:8].
- `rsp0_valid_o` / `rsp1_valid_o`  out  1  one-cycle completion pulse, issued for both reads and writes.
- `rsp0_data_o` / `rsp1_data_o`  out  16  read data, held until the next read completes on that port.
- `xbus_cs_n_o`  out  1  register select strobe, active low.
- `xbus_rd_nwr_o`  out  1  1 = read, 0 = write.
- `xbus_reg_num_o`  out  4  register number.
- `xbus_bytesel_o`  out  1  0 = even byte, 1 = odd byte.
- `xbus_data_o`  out  8  write byte.
- `xbus_data_i`  in  8  read byte.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE. A byte-phase flag (`bytesel`) selects the even or odd byte.
- IDLE:
  - The arbiter drives at most one `reqN_ready_o` combinationally from the valid inputs.
  - On accept, the port id, `wr`, `reg` and `data` are latched, and the block enters SETUP with phase 0.
  - Requester inputs are ignored after accept.
- SETUP:
  - Drive `reg_num`, `rd_nwr` and `bytesel`; drive `data_o` with the even byte (phase 0) or odd byte (phase 1) on writes.
  - `cs_n` = 1.
  - Stay `SETUP_CYCLES` cycles. If `SETUP_CYCLES` = 0, the state is skipped.
- STROBE:
  - `cs_n` = 0 for `STROBE_CYCLES` cycles.
  - On reads, sample `xbus_data_i` on the last strobe cycle into [15:8] (phase 0) or [7:0] (phase 1).
- HOLD:
  - `cs_n` = 1 with all other bus outputs unchanged, for `HOLD_CYCLES` cycles (0 skips the state).
  - Then go to SETUP with phase 1 if phase was 0, otherwise to DONE.
- DONE:
  - Pulse `rspN_valid_o` for the latched port; update `rspN_data_o` if the request was a read.
  - Next state is IDLE.
- Idle bus outputs: `cs_n` = 1, `rd_nwr` = 1, `reg_num`, `bytesel` and `data_o` = 0.
- Arbitration when both ports are valid follows the Configuration section. When only one port is valid, that port is granted.
- Reset mid-transaction:
  - `cs_n` rises immediately (asynchronous).
  - The transaction is dropped and no response is issued.
  - The arbitration pointer resets.

## Timing
- Reset values:
  - All `ready`, `rsp_valid` and `busy` outputs = 0.
  - `rsp*_data_o` = 0.
  - `xbus_cs_n_o` = 1, `xbus_rd_nwr_o` = 1.
  - `xbus_reg_num_o`, `xbus_bytesel_o`, `xbus_data_o` = 0.
- The accept edge is cycle 0. Each byte occupies B = `SETUP_CYCLES` + `STROBE_CYCLES` + `HOLD_CYCLES` cycles, starting at cycle 1.
- `rspN_valid_o` is high in cycle 2B+1. With default parameters B = 4, so the response is in cycle 9.
- IDLE is re-entered in cycle 2B+2. The next accept can occur at the end of that cycle, giving a throughput of one request per 2B+2 cycles.
- `ready` is never asserted outside IDLE.
- The phase counter is 3 bits and is reloaded on every state entry. A parameter outside its legal range is an elaboration `$error`.

## Configuration
- `XBUS_ROUND_ROBIN_EN` defined:
  - A 1-bit last-grant pointer is kept; on contention the port not granted last wins.
  - The pointer is set to 1 at reset, so port 0 wins the first contention.
- `XBUS_ROUND_ROBIN_EN` undefined:
  - Fixed priority: port 0 always wins contention.
  - The pointer register is not built.

## Structure
- `xbus_pkg`:
  - State enum `xbus_state_t`.
  - Byte-phase localparams `XBUS_EVEN` / `XBUS_ODD`.
  - Request struct `xbus_req_t` {`wr`, `reg_num`[3:0], `data`[15:0]}.
- Sub-module `xbus_arbiter2`: 2-way grant logic, containing the round-robin pointer when enabled.
- The FSM, counters and capture registers live in `xbus_sequencer`.

## Test plan
- Port 0 writes reg 3 = 0xA55A with default parameters:
  - `cs_n` is low in cycles 2–3 with `bytesel` = 0 and `data_o` = 0xA5.
  - `cs_n` is low in cycles 6–7 with `bytesel` = 1 and `data_o` = 0x5A.
  - `rsp0_valid_o` pulses in cycle 9.
- Port 1 reads reg 7, with the bus model returning 0x12 (even) and 0x34 (odd): `rsp1_data_o` = 0x1234 and `rsp1_valid_o` pulses exactly once.
- Both ports valid continuously for 4 requests:
  - With `XBUS_ROUND_ROBIN_EN`: grants are 0,1,0,1.
  - Without it: grants are 0,0,0,0.
- `SETUP_CYCLES` = 0, `HOLD_CYCLES` = 0, `STROBE_CYCLES` = 1: `cs_n` is low in cycles 1 and 2, and the response arrives in cycle 3.
- `reset_ni` asserted in cycle 3 of a read: `cs_n` = 1 asynchronously, no `rsp` pulse, and after release a port-0 request is accepted normally.
